// File: rtl/led_matrix_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : led_matrix_scan_ctrl
// Description : Row-by-row scan sequencer for a shift-register LED matrix.
//               Fetches a row from the framebuffer and shifts it into the
//               column register. It then blanks the display, latches the
//               columns, steps the row one-hot register and lights the row
//               for a fixed dwell time.
// Revision    : 1.0 - initial release
// ============================================================================
module led_matrix_scan_ctrl #(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int HALF  = 2,
    parameter int DWELL = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [COLS-1:0]         row_data,
    output logic [$clog2(ROWS)-1:0] row_addr,
    output logic                    csdi,
    output logic                    cclk,
    output logic                    le,
    output logic                    rsdi,
    output logic                    rclk,
    output logic                    oeb,
    output logic                    busy,
    output logic                    frame_done
);

    localparam int c_ROW_W = $clog2(ROWS);
    localparam int c_PH_W  = $clog2(2 * HALF) + 1;
    localparam int c_BIT_W = $clog2(COLS) + 1;
    localparam int c_CNT_W = $clog2(DWELL) + 1;

    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(ROWS - 1);
    localparam logic [c_PH_W-1:0]  c_PH_RISE  = c_PH_W'(HALF - 1);
    localparam logic [c_PH_W-1:0]  c_PH_LAST  = c_PH_W'(2 * HALF - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(COLS - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DWELL - 1);

    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_FETCH = 3'd1;
    localparam logic [2:0] c_S_SHIFT = 3'd2;
    localparam logic [2:0] c_S_BLANK = 3'd3;
    localparam logic [2:0] c_S_LATCH = 3'd4;
    localparam logic [2:0] c_S_RSTEP = 3'd5;
    localparam logic [2:0] c_S_DWELL = 3'd6;

    logic [2:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;      // FETCH/RSTEP cycle index and DWELL timer
    logic [c_PH_W-1:0]  r_ph;       // position inside one cclk bit period
    logic [c_BIT_W-1:0] r_bit;      // column bit currently on csdi
    logic [COLS-1:0]    r_shreg;
    logic [c_ROW_W-1:0] r_row;
    logic               r_csdi;
    logic               r_cclk;
    logic               r_le;
    logic               r_rsdi;
    logic               r_rclk;
    logic               r_oeb;
    logic               r_busy;
    logic               r_frame_done;

    logic [COLS-1:0]    w_shl;

    // Shift-left view of the column data; its MSB is the next bit to present.
    assign w_shl = r_shreg << 1;

    // Every pin is driven straight from a flop so the pads see glitch-free
    // edges; each state sets the pin values for the cycle that follows it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_S_IDLE;
            r_cnt        <= '0;
            r_ph         <= '0;
            r_bit        <= '0;
            r_shreg      <= '0;
            r_row        <= '0;
            r_csdi       <= 1'b0;
            r_cclk       <= 1'b0;
            r_le         <= 1'b0;
            r_rsdi       <= 1'b0;
            r_rclk       <= 1'b0;
            r_oeb        <= 1'b1;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_le         <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    r_oeb <= 1'b1;
                    if (enable) begin
                        r_state <= c_S_FETCH;
                        r_row   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                c_S_FETCH: begin
                    // The framebuffer answers one cycle after the address,
                    // so the row is captured at the end of the second cycle.
                    if (r_cnt == '0) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else begin
                        r_cnt   <= '0;
                        r_shreg <= row_data;
                        r_csdi  <= row_data[COLS-1];
                        r_ph    <= '0;
                        r_bit   <= '0;
                        r_state <= c_S_SHIFT;
                    end
                end
                c_S_SHIFT: begin
                    // Low half then high half of cclk; data moves on after
                    // the high half so csdi is stable around the rising edge.
                    if (r_ph == c_PH_LAST) begin
                        r_ph    <= '0;
                        r_cclk  <= 1'b0;
                        r_shreg <= w_shl;
                        if (r_bit == c_BIT_LAST) begin
                            r_csdi  <= 1'b0;
                            r_oeb   <= 1'b1;
                            r_state <= c_S_BLANK;
                        end else begin
                            r_bit  <= r_bit + 1'b1;
                            r_csdi <= w_shl[COLS-1];
                        end
                    end else begin
                        if (r_ph == c_PH_RISE) begin
                            r_cclk <= 1'b1;
                        end
                        r_ph <= r_ph + 1'b1;
                    end
                end
                c_S_BLANK: begin
                    r_le    <= 1'b1;
                    r_state <= c_S_LATCH;
                end
                c_S_LATCH: begin
                    // A single 1 is injected only when restarting at row 0;
                    // other rows just advance the one-hot pattern.
                    r_rsdi  <= (r_row == '0);
                    r_cnt   <= '0;
                    r_state <= c_S_RSTEP;
                end
                c_S_RSTEP: begin
                    if (r_cnt == '0) begin
                        r_rclk <= 1'b1;
                        r_cnt  <= r_cnt + 1'b1;
                    end else begin
                        r_rclk  <= 1'b0;
                        r_rsdi  <= 1'b0;
                        r_oeb   <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= c_S_DWELL;
                    end
                end
                c_S_DWELL: begin
                    if (r_cnt == c_CNT_LAST) begin
                        r_cnt <= '0;
                        if (r_row == c_ROW_LAST) begin
                            r_row        <= '0;
                            r_frame_done <= 1'b1;
                        end else begin
                            r_row <= r_row + 1'b1;
                        end
                        if (enable) begin
                            r_state <= c_S_FETCH;
                        end else begin
                            r_state <= c_S_IDLE;
                            r_oeb   <= 1'b1;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_S_IDLE;
                    r_oeb   <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign row_addr   = r_row;
    assign csdi       = r_csdi;
    assign cclk       = r_cclk;
    assign le         = r_le;
    assign rsdi       = r_rsdi;
    assign rclk       = r_rclk;
    assign oeb        = r_oeb;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_led_matrix_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_led_matrix_scan_ctrl
// Description : Self-checking bench for led_matrix_scan_ctrl (default build
//               plus a HALF=1/COLS=4/DWELL=1 build).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_led_matrix_scan_ctrl;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [7:0] row_data;
    logic [2:0] row_addr;
    logic       csdi, cclk, le, rsdi, rclk, oeb, busy, frame_done;

    logic       s_enable;
    logic [3:0] s_row_data;
    logic [2:0] s_row_addr;
    logic       s_csdi, s_cclk, s_le, s_rsdi, s_rclk, s_oeb, s_busy, s_frame_done;

    logic [7:0] fb   [8];
    logic [3:0] fb_s [8];

    int errors = 0;
    int checks = 0;
    int ov     = 0;
    int ov_s   = 0;

    bit mon_en = 1'b0;
    bit m_cclk = 1'b0;
    bit m_rclk = 1'b0;
    bit q_bits [$];
    bit q_rsdi [$];
    int q_row  [$];

    typedef struct {
        logic [7:0] data;
        logic [7:0] exp_bits;   // csdi at successive cclk rises, first in bit 7
    } vec_t;
    vec_t vecs [4];

    led_matrix_scan_ctrl dut (
        .clk(clk), .reset(reset), .enable(enable), .row_data(row_data),
        .row_addr(row_addr), .csdi(csdi), .cclk(cclk), .le(le), .rsdi(rsdi),
        .rclk(rclk), .oeb(oeb), .busy(busy), .frame_done(frame_done)
    );

    led_matrix_scan_ctrl #(.ROWS(8), .COLS(4), .HALF(1), .DWELL(1)) dut_s (
        .clk(clk), .reset(reset), .enable(s_enable), .row_data(s_row_data),
        .row_addr(s_row_addr), .csdi(s_csdi), .cclk(s_cclk), .le(s_le), .rsdi(s_rsdi),
        .rclk(s_rclk), .oeb(s_oeb), .busy(s_busy), .frame_done(s_frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Framebuffer models with one-cycle read latency.
    always @(posedge clk) begin
        row_data   <= fb[row_addr];
        s_row_data <= fb_s[s_row_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic sb_empty(input string name);
        checks++;
        errors++;
        $display("FAIL %s_scoreboard: actual=queue empty required=pending entry", name);
    endtask

    // Strobe exclusivity on both instances.
    always @(negedge clk) begin
        if ((cclk & rclk) | (cclk & le) | (rclk & le)) ov <= ov + 1;
        if ((s_cclk & s_rclk) | (s_cclk & s_le) | (s_rclk & s_le)) ov_s <= ov_s + 1;
    end

    // Scoreboard: pop expected csdi / rsdi / row at each strobe event.
    always @(negedge clk) begin
        if (mon_en) begin
            if (cclk && !m_cclk) begin
                if (q_bits.size() == 0) sb_empty("csdi");
                else check("csdi_at_cclk_rise", csdi, q_bits.pop_front());
            end
            if (rclk && !m_rclk) begin
                if (q_rsdi.size() == 0) sb_empty("rsdi");
                else check("rsdi_at_rclk_rise", rsdi, q_rsdi.pop_front());
            end
            if (le) begin
                if (q_row.size() == 0) sb_empty("row");
                else check("row_addr_at_le", row_addr, q_row.pop_front());
            end
        end
        m_cclk <= cclk;
        m_rclk <= rclk;
    end

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        enable   = 1'b0;
        s_enable = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    int  nrise, last_rise, oeb_rise, le_after, nle, fd_t, run, last_low, prev_le;
    int  fd_row;
    bit  p_cclk, p_oeb, gap_ok, per_ok, found, idle_seen, oeb_le_bad, rs_seen;
    logic [7:0] cap;
    logic [3:0] s_cap;
    logic       rs_val;

    initial begin
        vecs[0] = '{8'b1010_0011, 8'b1010_0011};
        vecs[1] = '{8'b0000_0001, 8'b0000_0001};
        vecs[2] = '{8'b1000_0000, 8'b1000_0000};
        vecs[3] = '{8'b0111_1110, 8'b0111_1110};
        for (int r = 0; r < 8; r++) begin
            fb[r]   = 8'h00;
            fb_s[r] = 4'h0;
        end
        reset = 1'b1; enable = 1'b0; s_enable = 1'b0;

        // ---------------- reset state and idle ----------------
        repeat (3) @(negedge clk);
        check("reset_pins", {csdi, cclk, le, rsdi, rclk, oeb, busy, frame_done}, 8'b0000_0100);
        check("reset_row_addr", row_addr, 0);
        check("reset_small_busy_oeb", {s_busy, s_oeb}, 2'b01);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_pins", {csdi, cclk, le, rsdi, rclk, oeb, busy, frame_done, row_addr},
                  {8'b0000_0100, 3'd0});
        end

        // ---------------- table: row 0 shift-out ----------------
        for (int vi = 0; vi < 4; vi++) begin
            do_reset();
            fb[0] = vecs[vi].data;
            fb[1] = 8'h5A;
            enable = 1'b1;
            nrise = 0; last_rise = -1; gap_ok = 1'b1; cap = '0;
            oeb_rise = -1; le_after = -1; nle = 0; p_cclk = 1'b0; p_oeb = 1'b1;
            for (int i = 1; i <= 200 && le_after < 0; i++) begin
                @(negedge clk);
                if (cclk && !p_cclk) begin
                    if (nrise < 8) begin
                        cap[7 - nrise] = csdi;
                        if (nrise > 0 && (i - last_rise) != 4) gap_ok = 1'b0;
                        last_rise = i;
                    end
                    nrise++;
                end
                if (oeb && !p_oeb) oeb_rise = i;
                if (le) begin
                    nle++;
                    if (oeb_rise >= 0 && le_after < 0) le_after = i - oeb_rise;
                end
                p_cclk = cclk;
                p_oeb  = oeb;
            end
            enable = 1'b0;
            check("tbl_csdi_sequence", cap, vecs[vi].exp_bits);
            check("tbl_cclk_rise_spacing4", gap_ok, 1);
            check("tbl_cclk_rises_two_rows", nrise, 16);
            check("tbl_le_after_oeb_rise", le_after, 1);
            check("tbl_le_pulses_two_rows", nle, 2);
        end

        // ---------------- full frame with scoreboard ----------------
        do_reset();
        for (int r = 0; r < 8; r++) begin
            fb[r] = 8'($urandom);
            for (int b = 7; b >= 0; b--) q_bits.push_back(fb[r][b]);
            q_rsdi.push_back(r == 0);
            q_row.push_back(r);
        end
        mon_en = 1'b1;
        enable = 1'b1;
        fd_t = -1; fd_row = -1;
        for (int i = 1; i <= 900 && fd_t < 0; i++) begin
            @(negedge clk);
            if (frame_done) begin
                fd_t   = i;
                fd_row = int'(row_addr);
            end
        end
        enable = 1'b0;
        check("frame_done_cycle", fd_t, 817);
        check("frame_wrap_row_addr", fd_row, 0);
        @(negedge clk);
        check("frame_done_one_cycle", frame_done, 0);
        mon_en = 1'b0;
        check("sb_csdi_left", q_bits.size(), 0);
        check("sb_rsdi_left", q_rsdi.size(), 0);
        check("sb_row_left", q_row.size(), 0);
        q_bits.delete(); q_rsdi.delete(); q_row.delete();

        // ---------------- enable dropped during row 3 SHIFT ----------------
        do_reset();
        enable = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (row_addr == 3'd3) found = 1'b1;
        end
        check("row3_reached", found, 1);
        repeat (11) @(negedge clk);      // FETCH cycle 2, then SHIFT cycles 1..10
        enable = 1'b0;
        run = 0; last_low = 0; idle_seen = 1'b0;
        for (int i = 0; i < 200 && !idle_seen; i++) begin
            @(negedge clk);
            if (!oeb) run++;
            else begin
                if (run > 0) last_low = run;
                run = 0;
            end
            if (!busy) idle_seen = 1'b1;
        end
        check("stop_reached_idle", idle_seen, 1);
        check("stop_last_dwell_len", last_low, 64);
        check("stop_idle_oeb_busy", {oeb, busy}, 2'b10);
        check("stop_row_addr", row_addr, 4);

        // ---------------- reset during row 5 DWELL ----------------
        do_reset();
        enable = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 700 && !found; i++) begin
            @(negedge clk);
            if (le && row_addr == 3'd5) found = 1'b1;
        end
        check("row5_latch_reached", found, 1);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            if (!oeb) found = 1'b1;
        end
        check("row5_dwell_reached", found, 1);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_pins", {oeb, busy, le, cclk, rclk}, 5'b10000);
        check("abort_row_addr", row_addr, 0);
        reset = 1'b0;
        found = 1'b0; rs_val = 1'b0; fd_row = -1;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (rclk) begin
                found  = 1'b1;
                rs_val = rsdi;
                fd_row = int'(row_addr);
            end
        end
        check("restart_rclk_seen", found, 1);
        check("restart_rsdi", rs_val, 1);
        check("restart_row_addr", fd_row, 0);

        // ---------------- small build: HALF=1, COLS=4, DWELL=1 ----------------
        do_reset();
        fb_s[0] = 4'b1001;
        for (int r = 1; r < 8; r++) fb_s[r] = 4'b0110;
        s_enable = 1'b1;
        nle = 0; nrise = 0; fd_t = -1; prev_le = -1; per_ok = 1'b1; gap_ok = 1'b1;
        last_rise = -1; s_cap = '0; p_cclk = 1'b0; oeb_le_bad = 1'b0; rs_seen = 1'b0; rs_val = 1'b0;
        for (int i = 1; i <= 200 && fd_t < 0; i++) begin
            @(negedge clk);
            if (s_le) begin
                if (prev_le >= 0 && (i - prev_le) != 15) per_ok = 1'b0;
                if (!s_oeb) oeb_le_bad = 1'b1;
                prev_le = i;
                nle++;
            end
            if (s_cclk && !p_cclk) begin
                if (nrise < 4) s_cap[3 - nrise] = s_csdi;
                if ((nrise % 4) != 0 && (i - last_rise) != 2) gap_ok = 1'b0;
                last_rise = i;
                nrise++;
            end
            if (s_rclk && !rs_seen) begin
                rs_seen = 1'b1;
                rs_val  = s_rsdi;
            end
            if (s_frame_done) fd_t = i;
            p_cclk = s_cclk;
        end
        s_enable = 1'b0;
        check("small_row_period15", per_ok, 1);
        check("small_le_count", nle, 8);
        check("small_cclk_every_cycle", gap_ok, 1);
        check("small_cclk_rises", nrise, 32);
        check("small_csdi_row0", s_cap, 4'b1001);
        check("small_oeb_high_at_le", oeb_le_bad, 0);
        check("small_first_rsdi", rs_val, 1);
        check("small_frame_done_cycle", fd_t, 121);
        check("small_wrap_row_addr", s_row_addr, 0);
        do_reset();

        check("strobe_overlap_default", ov, 0);
        check("strobe_overlap_small", ov_s, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/led_matrix_scan_ctrl.md
Name: led_matrix_scan_ctrl

Overview:
- Sequences the LED-matrix driver pins (row shift register: rclk/rsdi; column shift register: csdi/cclk; latch le; output enable oeb) from a row-addressed frame buffer.
- Each row: fetch the row's pixels, serially shift them into the column register, blank the display, latch, advance the row one-hot, then light it for a dwell period.
- Sits between the pong game logic's framebuffer and the matrix I/O pads, alongside the 7-segment and VGA outputs.

Parameters:
ROWS, 8, number of matrix rows (>=2)
COLS, 8, number of matrix columns (>=1)
HALF, 2, clk cycles per cclk half-period (>=1)
DWELL, 64, clk cycles a row stays lit (>=1)

Ports:
clk  input  1  system clock
reset  input  1  synchronous active-high reset
enable  input  1  run scanning; sampled in IDLE and at end of DWELL
row_data  input  COLS  pixel bits of row row_addr, bit COLS-1 = leftmost column
row_addr  output  $clog2(ROWS)  row being fetched/displayed
csdi  output  1  column serial data
cclk  output  1  column shift clock
le  output  1  column latch enable, one-cycle pulse
rsdi  output  1  row serial data (1 only when injecting row 0)
rclk  output  1  row shift clock
oeb  output  1  active-low output enable (1 = dark)
busy  output  1  high in any state except IDLE
frame_done  output  1  one-cycle pulse after the last row's DWELL

Behaviour:
- One clock, reset synchronous active-high. Clock port is clk, reset port is reset.
- All outputs are registered.
- Reset value: state IDLE, row_addr=0, oeb=1, all other outputs 0.
- Reset mid-operation aborts at the next edge. There is no partial-row completion.
- State machine (IDLE, FETCH, SHIFT, BLANK, LATCH, RSTEP, DWELL):
  - IDLE: oeb=1. If enable=1, go to FETCH with row=0.
  - FETCH, 2 cycles: row_addr held. row_data is sampled into the COLS-bit shift register at the end of the 2nd cycle. The framebuffer read has 1-cycle latency.
  - SHIFT, 2*HALF*COLS cycles: csdi = shift-register MSB for the whole bit period. cclk is low for HALF cycles, then high for HALF cycles. The register shifts left at the end of the high phase. Bit COLS-1 goes out first. oeb keeps its previous value (the previous row stays lit while shifting).
  - BLANK, 1 cycle: oeb=1.
  - LATCH, 1 cycle: le=1, oeb=1.
  - RSTEP, 2 cycles, oeb=1:
    - Cycle 1: rsdi=(row==0), rclk=0.
    - Cycle 2: rsdi held, rclk=1.
  - DWELL, DWELL cycles: oeb=0, rclk=0, rsdi=0.
  - End of DWELL: if row==ROWS-1, row wraps to 0 and frame_done pulses in the same cycle the state leaves DWELL. Otherwise row increments.
  - Then: if enable=1, go to FETCH; else go to IDLE with oeb=1.
- enable deasserting mid-row has no effect until the end of DWELL; the current row always finishes.
- Row period = 6 + 2*HALF*COLS + DWELL cycles. Defaults: 102 cycles per row, 816 per frame.
- Counters are sized $clog2 of their maximum plus 1. No overflow is possible for legal parameters.
- cclk, rclk and le are never high in the same cycle.

Test Plan:
- Reset, then enable=0 for 20 cycles -> oeb=1, busy=0, all other outputs 0, row_addr=0.
- Defaults, row 0 data 8'b1010_0011, enable=1 -> 8 cclk rising edges 4 cycles apart; csdi sampled at the rises = 1,0,1,0,0,0,1,1; le pulses once, 1 cycle after oeb rises.
- Full frame with defaults -> row_addr sequence 0..7, then wraps to 0; rsdi=1 at an rclk rise only for row 0; frame_done pulses exactly once, 816 cycles after the first FETCH.
- enable dropped in the 10th cycle of row 3's SHIFT -> row 3 completes its DWELL (oeb=0 for 64 cycles), then IDLE with oeb=1, busy=0, row_addr=4.
- reset asserted during DWELL of row 5 -> next cycle state IDLE, oeb=1, row_addr=0; re-enable restarts at row 0 with rsdi=1.
- HALF=1, COLS=4, DWELL=1 -> row period 15 cycles; cclk toggles every cycle; no cycle with two of cclk/rclk/le high.
